demux_32_bit_1_3_buf: RTL and testbench
=======================================

// Module: demux_32_bit_1_3_buf
// PURPOSE
//  - Inverse of the datapath 3:1 result select: routes one 32-bit producer stream to one of three consumer channels.
//  - in_sel picks the channel: 2'b00 -> ch0, 2'b01 -> ch1, 2'b10 -> ch2.
//  - One registered holding slot per channel; valid/ready handshake on the input and on every output.
//  - Sits between execute/memory result sources and the writeback, branch and store-forward consumers.
// PARAMETERS
//  - DATA_W  32  payload width of in_data and each out*_data
//  - CNT_W   16  width of the per-channel transfer counters (used only when DEMUX_COUNT_EN is defined)
// PORTS
//  - clk         in   1       single clock; all state updates on posedge
//  - rst_n       in   1       asynchronous, active-low reset
//  - in_valid    in   1       producer beat valid
//  - in_ready    out  1       block accepts the beat this cycle
//  - in_data     in   DATA_W  payload
//  - in_sel      in   2       destination channel code
//  - outK_valid  out  1       channel K (K = 0,1,2) slot holds a beat
//  - outK_ready  in   1       consumer K takes the beat this cycle
//  - outK_data   out  DATA_W  channel K payload, registered
//  - sel_err     out  1       sticky: an illegal in_sel (2'b11) beat was accepted
//  - cntK        out  CNT_W   beats delivered on channel K (DEMUX_COUNT_EN only)
// BEHAVIOUR
//  - Reset: rst_n low asynchronously clears all state. Every outK_valid = 0, outK_data = 0, sel_err = 0, cntK = 0.
//  - Reset mid-operation: held beats are discarded and never presented.
//  - Input transfer: occurs when in_valid & in_ready at posedge.
//  - Output transfer: occurs when outK_valid & outK_ready at posedge.
//  - Slot K is free when outK_valid = 0, or when outK_valid & outK_ready (draining this cycle).
//  - in_ready is combinational from in_sel and the slot states: equals "slot[in_sel] free". For in_sel = 2'b11, in_ready = 1.
//  - in_ready does not depend on in_valid.
//  - Latency: a beat accepted at edge N drives outK_valid = 1 and outK_data = beat from after edge N. Minimum latency is 1 cycle.
//  - Throughput: 1 beat/cycle per channel. Drain and refill of the same slot in one cycle is allowed: the new data replaces the old, and valid stays 1.
//  - Slot hold: while outK_valid & !outK_ready, outK_data and outK_valid are held stable. No overwrite is possible, because in_ready = 0 for that in_sel.
//  - Only the selected slot loads. The other two slots are unaffected by the input.
//  - Independent drains: each slot drains independently; several channels may drain in the same cycle.
//  - Illegal code 2'b11:
//    - the beat is consumed (in_ready = 1) and dropped;
//    - no outK_valid change;
//    - sel_err sets the next cycle and stays set until reset.
//  - in_valid = 0: no slot loads, regardless of in_sel or in_data.
// CONFIGURATION
//  - Macro DEMUX_COUNT_EN.
//  - Defined:
//    - cntK increments by 1 on every channel-K output transfer;
//    - wraps modulo 2^CNT_W (0xFFFF -> 0x0000 at default);
//    - no saturation, no clear other than reset.
//  - Undefined: cnt0..cnt2 ports and counter logic are absent.
// STRUCTURE
//  - Shared package/header holds:
//    - channel codes SEL_CH0 = 2'b00, SEL_CH1 = 2'b01, SEL_CH2 = 2'b10, SEL_BAD = 2'b11;
//    - default DATA_W.
//  - Sub-module demux_slot (one valid/data register pair, load/drain logic, optional counter) is instantiated 3 times.
//  - Top level decodes in_sel, forms in_ready, and holds sel_err.
// TESTING
//  - Reset release, idle inputs -> all outK_valid = 0, outK_data = 0, sel_err = 0, in_ready = 1 for every in_sel.
//  - Beats 0xDEADBEEF/sel 0, 0x12345678/sel 1, 0xCAFEF00D/sel 2 on back-to-back cycles, all outK_ready = 1 -> each appears on its channel exactly 1 cycle after acceptance, one cycle of valid.
//  - out1_ready = 0; send 0xAAAA0001 then 0xAAAA0002 to sel 1:
//    - first held, in_ready = 0 for sel 1;
//    - sel 0/2 still accepted;
//    - raise out1_ready -> 0xAAAA0001 then 0xAAAA0002, no loss or duplication.
//  - Slot 2 full with out2_ready = 1 and a new sel 2 beat 0x0000BEEF in the same cycle -> accepted; out2_valid stays 1 and out2_data = 0x0000BEEF next cycle.
//  - in_sel = 2'b11 with data 0xFFFFFFFF -> in_ready = 1, no outK_valid; sel_err = 1 next cycle and remains 1 after further legal beats.
//  - rst_n pulsed low while out0 is held:
//    - out0_valid drops immediately (asynchronously);
//    - with DEMUX_COUNT_EN, cnt0 = 0;
//    - 0x10000 ch0 transfers with CNT_W = 16 give cnt0 = 0x0000.

Source files
------------

// File: rtl/demux_32_bit_1_3_buf_pkg.sv
// rtl/demux_32_bit_1_3_buf_pkg.sv - shared channel codes and default widths for the 1:3 stream demux
package demux_32_bit_1_3_buf_pkg;

    localparam logic [1:0] SEL_CH0 = 2'b00;
    localparam logic [1:0] SEL_CH1 = 2'b01;
    localparam logic [1:0] SEL_CH2 = 2'b10;
    localparam logic [1:0] SEL_BAD = 2'b11;

    localparam int DATA_W_DEF = 32;
    localparam int CNT_W_DEF  = 16;
    localparam int NUM_CH     = 3;

endpackage

// File: rtl/demux_slot.sv
// rtl/demux_slot.sv - one-entry output holding slot with handshake, optional transfer counter (DEMUX_COUNT_EN)
module demux_slot
    import demux_32_bit_1_3_buf_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
`ifdef DEMUX_COUNT_EN
    ,
    parameter int CNT_W  = CNT_W_DEF
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic              free_o
`ifdef DEMUX_COUNT_EN
    ,
    output logic [CNT_W-1:0]  cnt_o
`endif
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              drain;

    assign drain   = valid_q & ready_i;
    // A slot draining this cycle can take a new beat in the same cycle.
    assign free_o  = ~valid_q | ready_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;

    // Next slot contents: a load wins over a drain so refill keeps valid high.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (drain) begin
            valid_d = 1'b0;
        end
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end
    end

    // Slot register; reset discards any held beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

`ifdef DEMUX_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Delivered-beat count, wraps naturally at 2^CNT_W.
    always_comb begin
        cnt_d = cnt_q;
        if (drain) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
`endif

endmodule

// File: rtl/demux_32_bit_1_3_buf.sv
// rtl/demux_32_bit_1_3_buf.sv - 1:3 buffered stream demux top, optional per-channel counters (DEMUX_COUNT_EN)
module demux_32_bit_1_3_buf
    import demux_32_bit_1_3_buf_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
`ifdef DEMUX_COUNT_EN
    ,
    parameter int CNT_W  = CNT_W_DEF
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_sel,
    output logic              out0_valid,
    input  logic              out0_ready,
    output logic [DATA_W-1:0] out0_data,
    output logic              out1_valid,
    input  logic              out1_ready,
    output logic [DATA_W-1:0] out1_data,
    output logic              out2_valid,
    input  logic              out2_ready,
    output logic [DATA_W-1:0] out2_data,
    output logic              sel_err
`ifdef DEMUX_COUNT_EN
    ,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1,
    output logic [CNT_W-1:0]  cnt2
`endif
);

    logic [NUM_CH-1:0] slot_free;
    logic [NUM_CH-1:0] slot_load;
    logic [NUM_CH-1:0] slot_ready;
    logic [NUM_CH-1:0] slot_valid;
    logic [DATA_W-1:0] slot_data [NUM_CH];
    logic              accept;
    logic              sel_err_q, sel_err_d;

    assign slot_ready = {out2_ready, out1_ready, out0_ready};

    // Ready follows the addressed slot; the illegal code is always swallowed.
    always_comb begin
        in_ready = 1'b1;
        case (in_sel)
            SEL_CH0: in_ready = slot_free[0];
            SEL_CH1: in_ready = slot_free[1];
            SEL_CH2: in_ready = slot_free[2];
            default: in_ready = 1'b1;
        endcase
    end

    assign accept = in_valid & in_ready;

    // Only the addressed slot loads on an accepted beat.
    always_comb begin
        slot_load    = '0;
        slot_load[0] = accept & (in_sel == SEL_CH0);
        slot_load[1] = accept & (in_sel == SEL_CH1);
        slot_load[2] = accept & (in_sel == SEL_CH2);
    end

    // Sticky flag for any accepted beat carrying the illegal code.
    always_comb begin
        sel_err_d = sel_err_q | (accept & (in_sel == SEL_BAD));
    end

    // Error flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_err_d;
        end
    end

`ifdef DEMUX_COUNT_EN
    logic [CNT_W-1:0] slot_cnt [NUM_CH];
`endif

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        demux_slot #(
            .DATA_W (DATA_W)
`ifdef DEMUX_COUNT_EN
            ,
            .CNT_W  (CNT_W)
`endif
        ) u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .load_i  (slot_load[k]),
            .data_i  (in_data),
            .ready_i (slot_ready[k]),
            .valid_o (slot_valid[k]),
            .data_o  (slot_data[k]),
            .free_o  (slot_free[k])
`ifdef DEMUX_COUNT_EN
            ,
            .cnt_o   (slot_cnt[k])
`endif
        );
    end

    assign out0_valid = slot_valid[0];
    assign out1_valid = slot_valid[1];
    assign out2_valid = slot_valid[2];
    assign out0_data  = slot_data[0];
    assign out1_data  = slot_data[1];
    assign out2_data  = slot_data[2];
    assign sel_err    = sel_err_q;

`ifdef DEMUX_COUNT_EN
    assign cnt0 = slot_cnt[0];
    assign cnt1 = slot_cnt[1];
    assign cnt2 = slot_cnt[2];
`endif

endmodule

// File: tb/tb_demux_32_bit_1_3_buf.sv
// tb/tb_demux_32_bit_1_3_buf.sv - scoreboard bench for the 1:3 buffered demux (DEMUX_COUNT_EN adds counter tests)
module tb_demux_32_bit_1_3_buf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] in_data;
    logic [1:0]  in_sel;
    logic        out0_valid, out0_ready, out1_valid, out1_ready, out2_valid, out2_ready;
    logic [31:0] out0_data, out1_data, out2_data;
    logic        sel_err;
`ifdef DEMUX_COUNT_EN
    logic [15:0] cnt0, cnt1, cnt2;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] q2[$];

    always #5 clk = ~clk;

    demux_32_bit_1_3_buf dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .out2_valid (out2_valid),
        .out2_ready (out2_ready),
        .out2_data  (out2_data),
        .sel_err    (sel_err)
`ifdef DEMUX_COUNT_EN
        ,
        .cnt0       (cnt0),
        .cnt1       (cnt1),
        .cnt2       (cnt2)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every output transfer pops and compares the oldest expected beat.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (out0_valid && out0_ready) begin
                if (q0.size() == 0) check("ch0 unexpected beat", out0_data, 32'hxxxxxxxx);
                else check("ch0 data", out0_data, q0.pop_front());
            end
            if (out1_valid && out1_ready) begin
                if (q1.size() == 0) check("ch1 unexpected beat", out1_data, 32'hxxxxxxxx);
                else check("ch1 data", out1_data, q1.pop_front());
            end
            if (out2_valid && out2_ready) begin
                if (q2.size() == 0) check("ch2 unexpected beat", out2_data, 32'hxxxxxxxx);
                else check("ch2 data", out2_data, q2.pop_front());
            end
        end
    end

    // Drive one beat from posedge+1; returns at posedge+1 after acceptance.
    task automatic send(input logic [1:0] sel, input logic [31:0] data);
        int wait_cyc;
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = data;
        wait_cyc = 0;
        @(negedge clk);
        while (!in_ready && wait_cyc < 50) begin
            wait_cyc++;
            @(negedge clk);
        end
        if (!in_ready) begin
            check("send timeout in_ready", {31'd0, in_ready}, 32'd1);
        end else begin
            case (sel)
                2'd0: q0.push_back(data);
                2'd1: q1.push_back(data);
                2'd2: q2.push_back(data);
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_data = 32'h0; in_sel = 2'b00;
        out0_ready = 1'b1; out1_ready = 1'b1; out2_ready = 1'b1;
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Reset state and idle ready for every code.
        check("rst out_valid", {29'd0, out2_valid, out1_valid, out0_valid}, 32'd0);
        check("rst out0_data", out0_data, 32'd0);
        check("rst out1_data", out1_data, 32'd0);
        check("rst out2_data", out2_data, 32'd0);
        check("rst sel_err", {31'd0, sel_err}, 32'd0);
        for (int s = 0; s < 4; s++) begin
            in_sel = 2'(s);
            #1;
            check("idle in_ready", {31'd0, in_ready}, 32'd1);
        end
        tick();

        // Back-to-back beats on three channels, one cycle latency, one cycle valid.
        send(2'd0, 32'hDEADBEEF);
        check("b2b out0 valid", {31'd0, out0_valid}, 32'd1);
        check("b2b out0 data", out0_data, 32'hDEADBEEF);
        send(2'd1, 32'h12345678);
        check("b2b out0 gone", {31'd0, out0_valid}, 32'd0);
        check("b2b out1 valid", {31'd0, out1_valid}, 32'd1);
        check("b2b out1 data", out1_data, 32'h12345678);
        send(2'd2, 32'hCAFEF00D);
        check("b2b out1 gone", {31'd0, out1_valid}, 32'd0);
        check("b2b out2 data", out2_data, 32'hCAFEF00D);
        tick();
        check("b2b out2 gone", {31'd0, out2_valid}, 32'd0);

        // Backpressure on channel 1 while other channels keep flowing.
        out1_ready = 1'b0;
        send(2'd1, 32'hAAAA0001);
        check("hold out1 valid", {31'd0, out1_valid}, 32'd1);
        in_sel = 2'd1;
        #1;
        check("hold in_ready sel1", {31'd0, in_ready}, 32'd0);
        send(2'd0, 32'h00000A0A);
        send(2'd2, 32'h00000B0B);
        check("hold out1 data", out1_data, 32'hAAAA0001);
        fork
            send(2'd1, 32'hAAAA0002);
            begin
                tick(); tick(); tick();
                out1_ready = 1'b1;
            end
        join
        check("release out1 data", out1_data, 32'hAAAA0002);
        tick(); tick();
        check("release q1 empty", q1.size(), 32'd0);

        // Drain and refill of slot 2 in the same cycle.
        out2_ready = 1'b0;
        send(2'd2, 32'h11112222);
        out2_ready = 1'b1;
        send(2'd2, 32'h0000BEEF);
        check("refill out2 valid", {31'd0, out2_valid}, 32'd1);
        check("refill out2 data", out2_data, 32'h0000BEEF);
        tick();

        // Illegal code: consumed, dropped, sticky error.
        in_sel = 2'b11;
        #1;
        check("bad in_ready", {31'd0, in_ready}, 32'd1);
        check("bad sel_err before", {31'd0, sel_err}, 32'd0);
        send(2'b11, 32'hFFFFFFFF);
        check("bad sel_err", {31'd0, sel_err}, 32'd1);
        check("bad no valid", {29'd0, out2_valid, out1_valid, out0_valid}, 32'd0);
        send(2'd0, 32'h01010101);
        send(2'd1, 32'h02020202);
        tick();
        check("bad sel_err sticky", {31'd0, sel_err}, 32'd1);

        // Asynchronous reset while ch0 holds a beat.
        out0_ready = 1'b0;
        send(2'd0, 32'h55555555);
        check("pre-rst out0 valid", {31'd0, out0_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst out0 valid", {31'd0, out0_valid}, 32'd0);
        check("async rst sel_err", {31'd0, sel_err}, 32'd0);
        q0.delete(); q1.delete(); q2.delete();
`ifdef DEMUX_COUNT_EN
        check("async rst cnt0", {16'd0, cnt0}, 32'd0);
`endif
        tick();
        rst_n = 1'b1;
        out0_ready = 1'b1;
        tick(); tick();
        check("post-rst out0 valid", {31'd0, out0_valid}, 32'd0);

`ifdef DEMUX_COUNT_EN
        // 0x10000 ch0 transfers wrap the counter back to zero.
        for (int i = 0; i < 65536; i++) begin
            send(2'd0, 32'(i));
            if (i == 4) check("cnt0 early", {16'd0, cnt0}, 32'd4);
            if (i == 65535) check("cnt0 max", {16'd0, cnt0}, 32'h0000FFFF);
        end
        tick();
        check("cnt0 wrap", {16'd0, cnt0}, 32'd0);
        check("cnt1 idle", {16'd0, cnt1}, 32'd0);
`endif

        tick(); tick();
        check("end q0 empty", q0.size(), 32'd0);
        check("end q1 empty", q1.size(), 32'd0);
        check("end q2 empty", q2.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
